// File: rtl/halt_report_tx.sv
// halt_report_tx: cycle counter plus halt/timeout watcher for FPGA runs.
// On the first halt strobe (or when the counter hits TIMEOUT_CYCLES) it sends
// one 6-byte report frame over an 8N1 UART TX line and then parks with done high.
module halt_report_tx #(
    parameter int unsigned CLKS_PER_BIT   = 434,
    parameter int unsigned TIMEOUT_CYCLES = 500000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        isHalt,
    input  logic [15:0] ret_val,
    output logic        tx,
    output logic        busy,
    output logic        done
);

    localparam int unsigned TimerW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TimerW-1:0] TimerMax = TimerW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        StCount,
        StStart,
        StData,
        StStop,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [31:0]       count_q, count_d;
    logic [TimerW-1:0] timer_q, timer_d;
    logic [2:0]        bit_q, bit_d;
    logic [2:0]        byte_q, byte_d;
    logic              halt_q, halt_d;
    logic [7:0]        ret_q, ret_d;
    logic              tx_q, tx_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [7:0]        cur_byte;
    logic              wrap;

    // Only the low byte of the return value is ever reported.
    logic unused_ret_hi;
    assign unused_ret_hi = ^ret_val[15:8];

    assign wrap = (timer_q == TimerMax);

    // Select the frame byte currently being shifted out.
    always_comb begin
        cur_byte = 8'h00;
        case (byte_q)
            3'd0:    cur_byte = halt_q ? 8'hA5 : 8'h5A;
            3'd1:    cur_byte = count_q[31:24];
            3'd2:    cur_byte = count_q[23:16];
            3'd3:    cur_byte = count_q[15:8];
            3'd4:    cur_byte = count_q[7:0];
            3'd5:    cur_byte = ret_q;
            default: cur_byte = 8'h00;
        endcase
    end

    // Next-state logic: counting, trigger capture, and bit/byte sequencing.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        timer_d = timer_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        halt_d  = halt_q;
        ret_d   = ret_q;

        if (state_q == StStart || state_q == StData || state_q == StStop) begin
            timer_d = wrap ? '0 : timer_q + 1'b1;
        end

        case (state_q)
            StCount: begin
                // The trigger edge does not increment, so count_q already holds
                // the value that gets reported.
                if (isHalt) begin
                    state_d = StStart;
                    halt_d  = 1'b1;
                    ret_d   = ret_val[7:0];
                    timer_d = '0;
                    bit_d   = 3'd0;
                    byte_d  = 3'd0;
                end else if (count_q == TIMEOUT_CYCLES) begin
                    state_d = StStart;
                    halt_d  = 1'b0;
                    ret_d   = 8'h00;
                    timer_d = '0;
                    bit_d   = 3'd0;
                    byte_d  = 3'd0;
                end else begin
                    count_d = count_q + 32'd1;
                end
            end
            StStart: begin
                if (wrap) begin
                    state_d = StData;
                    bit_d   = 3'd0;
                end
            end
            StData: begin
                if (wrap) begin
                    if (bit_q == 3'd7) begin
                        state_d = StStop;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            StStop: begin
                if (wrap) begin
                    if (byte_q == 3'd5) begin
                        state_d = StDone;
                    end else begin
                        state_d = StStart;
                        byte_d  = byte_q + 3'd1;
                    end
                end
            end
            StDone:  state_d = StDone;
            default: state_d = StCount;
        endcase
    end

    // Output decode; registered below so tx lags the state by one clock.
    always_comb begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        done_d = 1'b0;
        case (state_q)
            StStart: begin
                tx_d   = 1'b0;
                busy_d = 1'b1;
            end
            StData: begin
                tx_d   = cur_byte[bit_q];
                busy_d = 1'b1;
            end
            StStop: begin
                tx_d   = 1'b1;
                busy_d = 1'b1;
            end
            StDone:  done_d = 1'b1;
            default: tx_d = 1'b1;
        endcase
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StCount;
            count_q <= 32'd0;
            timer_q <= '0;
            bit_q   <= 3'd0;
            byte_q  <= 3'd0;
            halt_q  <= 1'b0;
            ret_q   <= 8'h00;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            timer_q <= timer_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            halt_q  <= halt_d;
            ret_q   <= ret_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign tx   = tx_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_halt_report_tx.sv
// Directed bench for halt_report_tx: decodes the UART frame and checks bytes,
// latency, frame length, sticky done and asynchronous reset behaviour.
module tb_halt_report_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, rst2_n;
    logic        is_halt, is_halt2;
    logic [15:0] ret_val, ret_val2;
    logic        tx1, busy1, done1;
    logic        tx2, busy2, done2;
    logic        use2;
    logic        tx_s, busy_s, done_s;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    halt_report_tx #(
        .CLKS_PER_BIT  (4),
        .TIMEOUT_CYCLES(100)
    ) u_dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .isHalt (is_halt),
        .ret_val(ret_val),
        .tx     (tx1),
        .busy   (busy1),
        .done   (done1)
    );

    // Full-size bit period; shortened timeout keeps the run short.
    halt_report_tx #(
        .CLKS_PER_BIT  (434),
        .TIMEOUT_CYCLES(20000)
    ) u_dut_uart (
        .clk    (clk),
        .rst_n  (rst2_n),
        .isHalt (is_halt2),
        .ret_val(ret_val2),
        .tx     (tx2),
        .busy   (busy2),
        .done   (done2)
    );

    assign tx_s   = use2 ? tx2 : tx1;
    assign busy_s = use2 ? busy2 : busy1;
    assign done_s = use2 ? done2 : done1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Wait for a start bit, then sample each bit in its middle.
    task automatic recv_byte(input int cpb, input int budget, output logic [7:0] b,
                             output int t_fall, output bit ok);
        int n;
        ok     = 1'b0;
        b      = 8'h00;
        t_fall = 0;
        n      = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (tx_s !== 1'b0 && n < budget);
        check("start_edge", 32'(tx_s), 32'd0);
        if (tx_s !== 1'b0) return;
        t_fall = cyc;
        repeat (cpb / 2) @(posedge clk);
        #1;
        check("start_bit", 32'(tx_s), 32'd0);
        for (int i = 0; i < 8; i++) begin
            repeat (cpb) @(posedge clk);
            #1;
            b[i] = tx_s;
        end
        repeat (cpb) @(posedge clk);
        #1;
        check("stop_bit", 32'(tx_s), 32'd1);
        ok = 1'b1;
    endtask

    task automatic run_frame(input string name, input int cpb, input int budget,
                             input logic [47:0] exp, input int t_trig);
        logic [7:0] b;
        int         tf, tf0, n;
        bit         ok;
        tf0 = 0;
        for (int i = 0; i < 6; i++) begin
            recv_byte(cpb, (i == 0) ? budget : 4 * cpb, b, tf, ok);
            if (!ok) return;
            if (i == 0) begin
                tf0 = tf;
                check({name, "_latency"}, 32'(tf - t_trig), 32'd1);
                check({name, "_busy"}, 32'(busy_s), 32'd1);
            end
            check($sformatf("%s_byte%0d", name, i), 32'(b), 32'(exp[47-8*i -: 8]));
        end
        n = 0;
        while (done_s !== 1'b1 && n < 4 * cpb) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({name, "_done"}, 32'(done_s), 32'd1);
        check({name, "_length"}, 32'(cyc - tf0), 32'(60 * cpb));
        check({name, "_busy_fall"}, 32'(busy_s), 32'd0);
        check({name, "_tx_idle"}, 32'(tx_s), 32'd1);
    endtask

    initial begin
        int t_trig, t_rel, lows, tf;
        logic [7:0] b;
        bit ok;

        rst_n    = 1'b0;
        rst2_n   = 1'b0;
        is_halt  = 1'b0;
        ret_val  = 16'h0000;
        is_halt2 = 1'b0;
        ret_val2 = 16'hC3C3;
        use2     = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_tx", 32'(tx1), 32'd1);
        check("rst_busy", 32'(busy1), 32'd0);
        check("rst_done", 32'(done1), 32'd0);

        // Halt at count 37; inputs wiggle during the frame and must not matter.
        @(negedge clk);
        ret_val = 16'h1234;
        rst_n   = 1'b1;
        repeat (37) @(posedge clk);
        #1 is_halt = 1'b1;
        @(posedge clk);
        #1;
        t_trig = cyc;
        check("trig_tx_high", 32'(tx1), 32'd1);
        check("trig_busy_low", 32'(busy1), 32'd0);
        fork
            run_frame("halt37", 4, 8, 48'hA5_00_00_00_25_34, t_trig);
            begin
                repeat (150) begin
                    @(negedge clk);
                    is_halt = 1'($urandom_range(1));
                    ret_val = 16'($urandom);
                end
            end
        join
        is_halt = 1'b1;
        lows    = 0;
        repeat (100) begin
            @(posedge clk);
            #1;
            if (tx1 !== 1'b1) lows++;
        end
        check("no_refire", 32'(lows), 32'd0);
        check("done_sticky", 32'(done1), 32'd1);

        // Reset in the middle of byte 2, then a fresh halt at count 5.
        @(negedge clk);
        rst_n   = 1'b0;
        is_halt = 1'b0;
        #1;
        check("rst_clears_done", 32'(done1), 32'd0);
        @(negedge clk);
        rst_n   = 1'b1;
        ret_val = 16'h0005;
        repeat (10) @(posedge clk);
        #1 is_halt = 1'b1;
        recv_byte(4, 8, b, tf, ok);
        recv_byte(4, 16, b, tf, ok);
        lows = 0;
        while (tx1 !== 1'b0 && lows < 16) begin
            @(posedge clk);
            #1;
            lows++;
        end
        repeat (10) @(posedge clk);
        #1;
        check("mid_byte2_tx_low", 32'(tx1), 32'd0);
        rst_n = 1'b0;
        #1;
        check("async_rst_tx", 32'(tx1), 32'd1);
        check("async_rst_busy", 32'(busy1), 32'd0);
        @(negedge clk);
        is_halt = 1'b0;
        ret_val = 16'hAB05;
        rst_n   = 1'b1;
        repeat (5) @(posedge clk);
        #1 is_halt = 1'b1;
        @(posedge clk);
        #1;
        t_trig = cyc;
        run_frame("halt5", 4, 8, 48'hA5_00_00_00_05_05, t_trig);

        // Timeout with halt held low; ret byte must be zero.
        @(negedge clk);
        rst_n   = 1'b0;
        is_halt = 1'b0;
        ret_val = 16'hBEEF;
        @(negedge clk);
        rst_n = 1'b1;
        t_rel = cyc;
        run_frame("timeout", 4, 200, 48'h5A_00_00_00_64_00, t_rel + 101);
        is_halt = 1'b1;
        repeat (50) @(posedge clk);
        #1;
        check("timeout_done_sticky", 32'(done1), 32'd1);
        check("timeout_tx_quiet", 32'(tx1), 32'd1);

        // Halt and timeout on the same edge: halt wins.
        @(negedge clk);
        rst_n   = 1'b0;
        is_halt = 1'b0;
        ret_val = 16'h0077;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (100) @(posedge clk);
        #1 is_halt = 1'b1;
        @(posedge clk);
        #1;
        t_trig = cyc;
        run_frame("halt_at_to", 4, 8, 48'hA5_00_00_00_64_77, t_trig);

        // Full bit period, timeout path.
        use2 = 1'b1;
        @(negedge clk);
        rst2_n = 1'b1;
        t_rel  = cyc;
        run_frame("uart434", 434, 20100, 48'h5A_00_00_4E_20_00, t_rel + 20001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
